// File: rtl/iltype_pkg.sv
// Shared opcodes, funct3 values, record kinds and the decoded-record layout for the I-type
// decoder slice.
package iltype_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;

  localparam logic [2:0] F3_SLLI = 3'd1;
  localparam logic [2:0] F3_SRXI = 3'd5;
  localparam logic [2:0] F3_LB   = 3'd0;
  localparam logic [2:0] F3_LH   = 3'd1;
  localparam logic [2:0] F3_LW   = 3'd2;
  localparam logic [2:0] F3_LBU  = 3'd4;
  localparam logic [2:0] F3_LHU  = 3'd5;

  localparam logic [31:0] NOP_WORD = 32'h00000013;

  typedef enum logic [1:0] {
    KIND_ALU_IMM = 2'd0,
    KIND_LOAD    = 2'd1,
    KIND_ILLEGAL = 2'd2
  } kind_e;

  // The immediate travels as its raw 12 bits and is sign-extended on the way out.
  typedef struct packed {
    kind_e       kind;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [11:0] imm;
  } rec_t;

  localparam int unsigned REC_W = $bits(rec_t);

endpackage

// File: rtl/iltype_skid_buffer.sv
// Two-entry valid/ready FIFO buffer with a registered in_ready that never looks at out_ready.
module iltype_skid_buffer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic [WIDTH-1:0] slot0_q, slot1_q;
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       count_q, count_d;
  logic             in_ready_q;
  logic             push, pop;

  assign push      = in_valid && in_ready_q;
  assign out_valid = (count_q != 2'd0);
  assign pop       = out_valid && out_ready;
  assign in_ready  = in_ready_q;
  assign out_data  = rd_ptr_q ? slot1_q : slot0_q;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot0_q    <= '0;
      slot1_q    <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      in_ready_q <= 1'b1;
    end else begin
      if (push) begin
        if (wr_ptr_q) slot1_q <= in_data;
        else          slot0_q <= in_data;
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q    <= count_d;
      in_ready_q <= (count_d < 2'd2);
    end
  end

endmodule

// File: rtl/iltype_instr_decoder.sv
// I-type ALU/load decoder with a 2-entry output buffer, per-kind retire counters and sticky error.
// Optional ILTYPE_NOP_FILTER_EN drops canonical NOPs at the input and counts them on cnt_nop.
module iltype_instr_decoder
  import iltype_pkg::*;
#(
  parameter int unsigned WORD_SIZE = 32,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_SIZE-1:0] in_instr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [1:0]           out_kind,
  output logic [2:0]           out_funct3,
  output logic [4:0]           out_rd,
  output logic [4:0]           out_rs1,
  output logic [WORD_SIZE-1:0] out_imm,
  input  logic                 cnt_clr,
  output logic [CNT_W-1:0]     cnt_alu,
  output logic [CNT_W-1:0]     cnt_load,
  output logic [CNT_W-1:0]     cnt_illegal,
`ifdef ILTYPE_NOP_FILTER_EN
  output logic [CNT_W-1:0]     cnt_nop,
`endif
  output logic                 err_sticky
);

  function automatic rec_t decode_word(input logic [31:0] instr);
    rec_t       r;
    logic [6:0] hi;
    r.funct3 = instr[14:12];
    r.rd     = instr[11:7];
    r.rs1    = instr[19:15];
    r.imm    = instr[31:20];
    r.kind   = KIND_ILLEGAL;
    hi       = instr[31:25];
    case (instr[6:0])
      OPC_OP_IMM: begin
        r.kind = KIND_ALU_IMM;
        if (r.funct3 == F3_SLLI && hi != 7'h00) r.kind = KIND_ILLEGAL;
        if (r.funct3 == F3_SRXI && hi != 7'h00 && hi != 7'h20) r.kind = KIND_ILLEGAL;
      end
      OPC_LOAD: begin
        case (r.funct3)
          F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: r.kind = KIND_LOAD;
          default:                             r.kind = KIND_ILLEGAL;
        endcase
      end
      default: r.kind = KIND_ILLEGAL;
    endcase
    return r;
  endfunction

  rec_t in_rec, out_rec;
  logic buf_in_valid;
  logic fire;

  assign in_rec = decode_word(in_instr[31:0]);

`ifdef ILTYPE_NOP_FILTER_EN
  logic             is_nop;
  logic [CNT_W-1:0] cnt_nop_q;

  // NOPs are consumed under the normal handshake but never written into the buffer.
  assign is_nop       = (in_instr[31:0] == NOP_WORD);
  assign buf_in_valid = in_valid && !is_nop;
  assign cnt_nop      = cnt_nop_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_nop_q <= '0;
    end else if (cnt_clr) begin
      cnt_nop_q <= '0;
    end else if (in_valid && in_ready && is_nop && cnt_nop_q != {CNT_W{1'b1}}) begin
      cnt_nop_q <= cnt_nop_q + 1'b1;
    end
  end
`else
  assign buf_in_valid = in_valid;
`endif

  iltype_skid_buffer #(
    .WIDTH (REC_W)
  ) u_skid (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (buf_in_valid),
    .in_ready  (in_ready),
    .in_data   (in_rec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_rec)
  );

  assign fire       = out_valid && out_ready;
  assign out_kind   = out_rec.kind;
  assign out_funct3 = out_rec.funct3;
  assign out_rd     = out_rec.rd;
  assign out_rs1    = out_rec.rs1;
  assign out_imm    = {{(WORD_SIZE - 12){out_rec.imm[11]}}, out_rec.imm};

  logic [CNT_W-1:0] cnt_alu_q, cnt_load_q, cnt_illegal_q;
  logic             err_q;

  // Clear wins over a same-cycle fire; that fire goes uncounted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_alu_q     <= '0;
      cnt_load_q    <= '0;
      cnt_illegal_q <= '0;
      err_q         <= 1'b0;
    end else if (cnt_clr) begin
      cnt_alu_q     <= '0;
      cnt_load_q    <= '0;
      cnt_illegal_q <= '0;
      err_q         <= 1'b0;
    end else if (fire) begin
      unique case (out_rec.kind)
        KIND_ALU_IMM: if (cnt_alu_q != {CNT_W{1'b1}}) cnt_alu_q <= cnt_alu_q + 1'b1;
        KIND_LOAD:    if (cnt_load_q != {CNT_W{1'b1}}) cnt_load_q <= cnt_load_q + 1'b1;
        KIND_ILLEGAL: begin
          if (cnt_illegal_q != {CNT_W{1'b1}}) cnt_illegal_q <= cnt_illegal_q + 1'b1;
          err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign cnt_alu     = cnt_alu_q;
  assign cnt_load    = cnt_load_q;
  assign cnt_illegal = cnt_illegal_q;
  assign err_sticky  = err_q;

endmodule

// File: tb/tb_iltype_instr_decoder.sv
// Scoreboard bench for iltype_instr_decoder: expected records queued on accept, checked on fire.
module tb_iltype_instr_decoder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready;
  logic [31:0] in_instr;
  logic        out_valid, out_ready;
  logic [1:0]  out_kind;
  logic [2:0]  out_funct3;
  logic [4:0]  out_rd, out_rs1;
  logic [31:0] out_imm;
  logic        cnt_clr;
  logic [15:0] cnt_alu, cnt_load, cnt_illegal;
  logic        err_sticky;
`ifdef ILTYPE_NOP_FILTER_EN
  logic [15:0] cnt_nop;
  int          m_nop;
`endif

  iltype_instr_decoder #(
    .WORD_SIZE (32),
    .CNT_W     (16)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_kind    (out_kind),
    .out_funct3  (out_funct3),
    .out_rd      (out_rd),
    .out_rs1     (out_rs1),
    .out_imm     (out_imm),
    .cnt_clr     (cnt_clr),
    .cnt_alu     (cnt_alu),
    .cnt_load    (cnt_load),
    .cnt_illegal (cnt_illegal),
`ifdef ILTYPE_NOP_FILTER_EN
    .cnt_nop     (cnt_nop),
`endif
    .err_sticky  (err_sticky)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int m_alu, m_load, m_ill;
  logic [46:0] sb_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference decode: {kind, funct3, rd, rs1, imm32}
  function automatic logic [46:0] exp_rec(input logic [31:0] w);
    logic [1:0] k;
    logic [2:0] f3;
    logic [6:0] top;
    f3  = w[14:12];
    top = w[31:25];
    if (w[6:0] == 7'h13) begin
      k = 2'd0;
      if (f3 == 3'd1 && top != 7'h00) k = 2'd2;
      if (f3 == 3'd5 && !(top == 7'h00 || top == 7'h20)) k = 2'd2;
    end else if (w[6:0] == 7'h03) begin
      k = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) ? 2'd2 : 2'd1;
    end else begin
      k = 2'd2;
    end
    return {k, f3, w[11:7], w[19:15], {{20{w[31]}}, w[31:20]}};
  endfunction

  // Scoreboard/model: sampled on the negedge, reflects what the next posedge will do.
  always @(negedge clk) begin
    if (reset_n) begin
      if (out_valid && out_ready) begin
        check_eq("sb_avail", 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0)
          check_eq("record", {out_kind, out_funct3, out_rd, out_rs1, out_imm}, sb_q.pop_front());
      end
      if (cnt_clr) begin
        m_alu = 0; m_load = 0; m_ill = 0;
`ifdef ILTYPE_NOP_FILTER_EN
        m_nop = 0;
`endif
      end else if (out_valid && out_ready) begin
        if (out_kind == 2'd0 && m_alu < 65535) m_alu++;
        if (out_kind == 2'd1 && m_load < 65535) m_load++;
        if (out_kind == 2'd2 && m_ill < 65535) m_ill++;
      end
      if (in_valid && in_ready) begin
`ifdef ILTYPE_NOP_FILTER_EN
        if (in_instr == 32'h00000013) begin
          if (!cnt_clr && m_nop < 65535) m_nop++;
        end else begin
          sb_q.push_back(exp_rec(in_instr));
        end
`else
        sb_q.push_back(exp_rec(in_instr));
`endif
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 of the accepting edge.
  task automatic send(input logic [31:0] w);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_instr = w;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check_eq("send_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic clear_model();
    sb_q.delete();
    m_alu = 0; m_load = 0; m_ill = 0;
`ifdef ILTYPE_NOP_FILTER_EN
    m_nop = 0;
`endif
  endtask

  initial begin
    int t0;
    int n;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    out_ready = 1'b0;
    cnt_clr   = 1'b0;
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_imm", 64'(out_imm), 64'd0);
    check_eq("rst_kind", 64'(out_kind), 64'd0);
    check_eq("rst_cnt_alu", 64'(cnt_alu), 64'd0);
    check_eq("rst_err", 64'(err_sticky), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);

    // addi x5,x3,-1
    step();
    out_ready = 1'b1;
    send(32'hFFF18293);
    @(negedge clk);
    check_eq("t1_valid", 64'(out_valid), 64'd1);
    check_eq("t1_kind", 64'(out_kind), 64'd0);
    check_eq("t1_rd", 64'(out_rd), 64'd5);
    check_eq("t1_rs1", 64'(out_rs1), 64'd3);
    check_eq("t1_imm", 64'(out_imm), 64'hFFFFFFFF);
    @(negedge clk);
    check_eq("t1_cnt_alu", 64'(cnt_alu), 64'd1);

    // srai legal, then bad shift immediate
    step();
    send(32'h40715093);
    @(negedge clk);
    check_eq("t2_kind", 64'(out_kind), 64'd0);
    check_eq("t2_imm", 64'(out_imm), 64'h00000407);
    @(negedge clk);
    check_eq("t2_err0", 64'(err_sticky), 64'd0);
    step();
    send(32'h20715093);
    @(negedge clk);
    check_eq("t2_kind_ill", 64'(out_kind), 64'd2);
    @(negedge clk);
    check_eq("t2_cnt_ill", 64'(cnt_illegal), 64'd1);
    check_eq("t2_err1", 64'(err_sticky), 64'd1);

    // lbu, then load with funct3=3
    step();
    send(32'h01034203);
    @(negedge clk);
    check_eq("t3_kind", 64'(out_kind), 64'd1);
    check_eq("t3_f3", 64'(out_funct3), 64'd4);
    check_eq("t3_rd", 64'(out_rd), 64'd4);
    check_eq("t3_rs1", 64'(out_rs1), 64'd6);
    check_eq("t3_imm", 64'(out_imm), 64'h10);
    step();
    send(32'h01033203);
    @(negedge clk);
    check_eq("t3_kind_ill", 64'(out_kind), 64'd2);

    // Backpressure: A, B fill the buffer, C is held
    step();
    out_ready = 1'b0;
    send(32'h00108093);
    send(32'h00210113);
    in_valid = 1'b1;
    in_instr = 32'h00318193;
    repeat (3) begin
      @(negedge clk);
      check_eq("t4_full_ready", 64'(in_ready), 64'd0);
      check_eq("t4_hold_rd", 64'(out_rd), 64'd1);
    end
    step();
    out_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("t4_c_accept", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("t4_drained", 64'(sb_q.size()), 64'd0);

    // Steady-state streaming: one word per cycle
    step();
    t0 = cyc;
    for (int i = 0; i < 8; i++) send({12'(i), 5'(i), 3'd0, 5'(i + 1), 7'h13});
    check_eq("t4_thruput", 64'(cyc - t0), 64'd8);
    repeat (3) @(negedge clk);
    check_eq("t4_drained2", 64'(sb_q.size()), 64'd0);
    check_eq("t4_cnt_alu", 64'(cnt_alu), 64'(m_alu));

    // Clear coincident with a fire
    step();
    send(32'h00738393);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    @(negedge clk);
    check_eq("t5_clr_alu", 64'(cnt_alu), 64'd0);
    check_eq("t5_clr_ill", 64'(cnt_illegal), 64'd0);
    check_eq("t5_clr_err", 64'(err_sticky), 64'd0);

    // Saturation
    step();
    for (int i = 0; i < 65535; i++) send(32'h00100093);
    repeat (3) @(negedge clk);
    check_eq("t5_sat_max", 64'(cnt_alu), 64'hFFFF);
    step();
    send(32'h00100093);
    repeat (3) @(negedge clk);
    check_eq("t5_sat_hold", 64'(cnt_alu), 64'hFFFF);
    check_eq("t5_sat_model", 64'(cnt_alu), 64'(m_alu));

    // Reset with two buffered records
    step();
    out_ready = 1'b0;
    send(32'h00500293);
    send(32'h00600313);
    @(negedge clk);
    check_eq("t6_pre_valid", 64'(out_valid), 64'd1);
    step();
    reset_n = 1'b0;
    clear_model();
    #1;
    check_eq("t6_rst_valid", 64'(out_valid), 64'd0);
    check_eq("t6_rst_cnt", 64'(cnt_alu), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("t6_post_valid", 64'(out_valid), 64'd0);
    check_eq("t6_post_ready", 64'(in_ready), 64'd1);

    step();
    out_ready = 1'b1;
`ifdef ILTYPE_NOP_FILTER_EN
    repeat (3) send(32'h00000013);
    @(negedge clk);
    check_eq("t6_nop_valid", 64'(out_valid), 64'd0);
    check_eq("t6_nop_cnt", 64'(cnt_nop), 64'd3);
    check_eq("t6_nop_model", 64'(cnt_nop), 64'(m_nop));
`else
    send(32'h00000013);
    @(negedge clk);
    check_eq("t6_nop_valid", 64'(out_valid), 64'd1);
    check_eq("t6_nop_kind", 64'(out_kind), 64'd0);
    check_eq("t6_nop_imm", 64'(out_imm), 64'd0);
`endif
    repeat (3) @(negedge clk);
    check_eq("final_drained", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/iltype_instr_decoder.md
Name: iltype_instr_decoder

Overview:
- Consumes the I-type ALU / load instruction stream on the core's imem-response side and decodes each 32-bit word into fields: kind, funct3, rd, rs1 and the sign-extended immediate.
- Flags illegal encodings: bad shift immediates, bad load widths and unknown opcodes.
- Keeps per-kind retire counters and a sticky error flag.
- Sits between the instruction source and the sodor5 verification checker; buffered valid/ready on both sides.

Parameters:
WORD_SIZE, 32, instruction and immediate width
CNT_W, 16, width of each saturating counter

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  instruction word offered
in_ready  out  1  decoder can accept
in_instr  in  WORD_SIZE  raw instruction
out_valid  out  1  decoded record available
out_ready  in  1  consumer accepts record
out_kind  out  2  0=ALU_IMM, 1=LOAD, 2=ILLEGAL
out_funct3  out  3  instr[14:12]
out_rd  out  5  instr[11:7]
out_rs1  out  5  instr[19:15]
out_imm  out  WORD_SIZE  sign-extended instr[31:20]
cnt_clr  in  1  synchronous clear of counters and sticky error
cnt_alu  out  CNT_W  ALU_IMM records emitted
cnt_load  out  CNT_W  LOAD records emitted
cnt_illegal  out  CNT_W  ILLEGAL records emitted
err_sticky  out  1  set on first ILLEGAL emitted

Behaviour:
- Reset: async on reset_n low. Both buffer entries empty; out_valid=0; in_ready=1 after reset releases; all out_* fields 0; counters 0; err_sticky=0. Reset mid-transfer discards buffered records without emitting them.
- Handshakes:
  - Accept occurs when in_valid && in_ready.
  - Fire occurs when out_valid && out_ready.
  - out_valid and the out_* fields stay stable while out_valid && !out_ready.
- Latency: a word accepted in cycle N appears on out_* in cycle N+1 when the buffer was empty (registered decode).
- Buffering: 2-entry skid buffer holds decoded records.
  - in_ready = (occupancy < 2) and is registered; it never depends combinationally on out_ready.
  - Accept and fire in the same cycle leave occupancy unchanged.
  - At full occupancy, in_valid is ignored (no accept).
  - Records leave in FIFO order.
- Decode, opcode = instr[6:0]:
  - 7'b0010011: ALU_IMM. Illegal if funct3==1 and imm[11:5]!=0. Illegal if funct3==5 and imm[11:5] is neither 7'h00 nor 7'h20.
  - 7'b0000011: LOAD. funct3 must be in {0,1,2,4,5}; 3, 6 and 7 are ILLEGAL.
  - Any other opcode: ILLEGAL.
  - ILLEGAL records still carry the raw field values.
- Immediate: out_imm = {{20{instr[31]}}, instr[31:20]} for every kind.
- Counters:
  - Increment on fire only, selected by out_kind.
  - Saturate at 2^CNT_W-1; no wrap.
  - err_sticky sets on fire of an ILLEGAL record.
  - cnt_clr has priority over a simultaneous fire: counters go to 0 and that fire is not counted.

Optional Feature:
- Macro ILTYPE_NOP_FILTER_EN.
- Defined:
  - Accepted words equal to 32'h00000013 (canonical NOP / reset filler) are consumed but never enter the buffer or reach out_*.
  - They are counted in an extra output cnt_nop [CNT_W-1:0], saturating, cleared by cnt_clr.
  - in_ready rules are unchanged.
- Undefined: the NOP is emitted as ALU_IMM (rd=0, rs1=0, funct3=0, imm=0), and the cnt_nop port is absent.

Decomposition:
- Package iltype_pkg holds:
  - OPC_OP_IMM = 7'b0010011 and OPC_LOAD = 7'b0000011
  - kind enum (KIND_ALU_IMM, KIND_LOAD, KIND_ILLEGAL)
  - funct3 constants (F3_SLLI=1, F3_SRXI=5, F3_LB=0, F3_LH=1, F3_LW=2, F3_LBU=4, F3_LHU=5)
  - NOP_WORD = 32'h00000013
  - decoded-record struct typedef
- Sub-module iltype_skid_buffer: 2-entry valid/ready buffer, parameterised on record width, async active-low reset.
- The decoder top holds the combinational decode function, the counters and the sticky error.

Test Plan:
1. Reset, then in 0xFFF18293 (addi x5,x3,-1) with out_ready=1 -> next cycle out_valid=1, kind=ALU_IMM, rd=5, rs1=3, funct3=0, imm=0xFFFFFFFF; cnt_alu=1.
2. In 0x40715093 (srai x1,x2,7) -> ALU_IMM, imm=0x00000407, err_sticky=0. Then 0x20715093 -> ILLEGAL, cnt_illegal=1, err_sticky=1.
3. In 0x01034203 (lbu x4,16(x6)) -> LOAD, funct3=4, rd=4, rs1=6, imm=0x10. Then 0x01033203 (funct3=3) -> ILLEGAL.
4. out_ready=0, three back-to-back valid words A, B, C:
   - in_ready drops after A and B are accepted; C is held.
   - out_ready=1 -> records emerge A, B, C in order, none lost or duplicated.
   - In steady state with out_ready=1, throughput is one record per cycle.
5. Drive cnt_clr in the same cycle as an ALU_IMM fire -> cnt_alu=0 and err_sticky=0. Force cnt_alu to 0xFFFF with CNT_W=16, then fire one more -> stays 0xFFFF.
6. Pulse reset_n low with 2 records buffered -> out_valid=0 immediately, counters 0. With ILTYPE_NOP_FILTER_EN, feed 0x00000013 ×3 -> out_valid stays 0, cnt_nop=3.
